// File: rtl/ws2812_bit_enc.sv
// ws2812_bit_enc
// Serialises single bits into the WS2812 one-wire pulse format. Each bit is
// a high phase followed by a low phase whose lengths depend on the bit value.
// Bits presented back to back produce a gapless waveform. An optional latch
// gap (a long low period) can be requested at the end of a frame.
//
// Optional feature macro: WS2812_LATCH_GAP_EN
//   defined   : frame_end_i requests a T_RST-cycle latch gap (RST state),
//               ending with a rst_done_o pulse.
//   undefined : frame_end_i is ignored, RST is never entered and
//               rst_done_o is tied to 0.
//
// Ports
//   clk_i        in   single clock, rising edge
//   rst_n_i      in   asynchronous active-low reset
//   bit_data_i   in   bit value to encode (sampled only on acceptance)
//   bit_valid_i  in   bit_data_i is valid
//   bit_ready_o  out  encoder can accept a bit this cycle
//   frame_end_i  in   request a latch gap after the current bit
//   wave_o       out  registered serial line to the LED chain
//   bit_done_o   out  pulse on the last cycle of each bit
//   rst_done_o   out  pulse on the last cycle of a latch gap
//   busy_o       out  high whenever the encoder is not idle
module ws2812_bit_enc #(
    parameter int CNT_WIDTH = 12,
    parameter int T0H       = 16,
    parameter int T0L       = 34,
    parameter int T1H       = 32,
    parameter int T1L       = 18,
    parameter int T_RST     = 2000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic bit_data_i,
    input  logic bit_valid_i,
    output logic bit_ready_o,
    input  logic frame_end_i,
    output logic wave_o,
    output logic bit_done_o,
    output logic rst_done_o,
    output logic busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        RST
    } state_t;

    // Counter reload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [CNT_WIDTH-1:0] LOAD_T0H = CNT_WIDTH'(T0H - 1);
    localparam logic [CNT_WIDTH-1:0] LOAD_T0L = CNT_WIDTH'(T0L - 1);
    localparam logic [CNT_WIDTH-1:0] LOAD_T1H = CNT_WIDTH'(T1H - 1);
    localparam logic [CNT_WIDTH-1:0] LOAD_T1L = CNT_WIDTH'(T1L - 1);
    localparam logic [CNT_WIDTH-1:0] LOAD_RST = CNT_WIDTH'(T_RST - 1);

    state_t               state;
    state_t               state_next;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic                 bit_q;
    logic                 cnt_zero;
    logic                 accept;
    logic                 gap_req;

    assign cnt_zero = (cnt == '0);
    assign accept   = bit_valid_i && bit_ready_o;

`ifdef WS2812_LATCH_GAP_EN
    assign gap_req = frame_end_i;
`else
    // Without the latch gap the request line and gap length have no effect.
    logic unused_gap;
    assign gap_req    = 1'b0;
    assign unused_gap = ^{frame_end_i, LOAD_RST};
`endif

    // State register. wave_o is registered from the next state so the line
    // rises exactly one cycle after acceptance and is glitch free.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state  <= IDLE;
            cnt    <= '0;
            bit_q  <= 1'b0;
            wave_o <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            wave_o <= (state_next == HIGH);
            if (accept) begin
                bit_q <= bit_data_i;
            end
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                // A waiting bit wins over a latch request.
                if (accept) begin
                    state_next = HIGH;
                    cnt_next   = bit_data_i ? LOAD_T1H : LOAD_T0H;
                end else if (gap_req) begin
                    state_next = RST;
                    cnt_next   = LOAD_RST;
                end
            end
            HIGH: begin
                if (cnt_zero) begin
                    state_next = LOW;
                    cnt_next   = bit_q ? LOAD_T1L : LOAD_T0L;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            LOW: begin
                // The last low cycle doubles as the acceptance slot for the
                // next bit, which keeps consecutive bits gapless.
                if (cnt_zero) begin
                    if (accept) begin
                        state_next = HIGH;
                        cnt_next   = bit_data_i ? LOAD_T1H : LOAD_T0H;
                    end else if (gap_req) begin
                        state_next = RST;
                        cnt_next   = LOAD_RST;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            RST: begin
                if (cnt_zero) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Moore outputs decoded from state and counter.
    always_comb begin
        bit_ready_o = (state == IDLE) || ((state == LOW) && cnt_zero);
        bit_done_o  = (state == LOW) && cnt_zero;
        busy_o      = (state != IDLE);
`ifdef WS2812_LATCH_GAP_EN
        rst_done_o  = (state == RST) && cnt_zero;
`else
        rst_done_o  = 1'b0;
`endif
    end

endmodule

// File: tb/tb_ws2812_bit_enc.sv
// tb_ws2812_bit_enc
// Drives random and directed bit streams into ws2812_bit_enc and compares
// every output, every cycle, against a waveform built from the bit list.
module tb_ws2812_bit_enc;

    localparam int T0H   = 16;
    localparam int T0L   = 34;
    localparam int T1H   = 32;
    localparam int T1L   = 18;
    localparam int T_RST = 2000;
`ifdef WS2812_LATCH_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic bit_data;
    logic bit_valid;
    logic bit_ready;
    logic frame_end;
    logic wave;
    logic bit_done;
    logic rst_done;
    logic busy;

    int checks;
    int fails;
    bit tx_bits[$];

    ws2812_bit_enc dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .bit_data_i  (bit_data),
        .bit_valid_i (bit_valid),
        .bit_ready_o (bit_ready),
        .frame_end_i (frame_end),
        .wave_o      (wave),
        .bit_done_o  (bit_done),
        .rst_done_o  (rst_done),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, and on mismatch counts and reports it.
    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0b expected=%0b", tag, observed, expected);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, " wave"},     wave,      1'b0);
        checkOutput({tag, " busy"},     busy,      1'b0);
        checkOutput({tag, " ready"},    bit_ready, 1'b1);
        checkOutput({tag, " bitdone"},  bit_done,  1'b0);
        checkOutput({tag, " rstdone"},  rst_done,  1'b0);
    endtask

    // Sends tx_bits back to back with frame_end held at fe, starting from
    // IDLE, and checks the whole resulting waveform plus the return to IDLE.
    // The expected waveform is simply each bit's high run followed by its
    // low run, with an optional latch gap appended.
    task automatic applyStimulus(input string name, input bit fe);
        logic exp_wave[$];
        int   ends[$];
        int   total;
        int   last;
        int   nxt;
        bit   gap;
        bit   is_end;
        logic e_wave;
        string tag;
        total = 0;
        foreach (tx_bits[i]) begin
            int th;
            int tl;
            th = tx_bits[i] ? T1H : T0H;
            tl = tx_bits[i] ? T1L : T0L;
            for (int c = 0; c < th; c++) exp_wave.push_back(1'b1);
            for (int c = 0; c < tl; c++) exp_wave.push_back(1'b0);
            total += th + tl;
            ends.push_back(total);
        end
        gap  = fe && GAP_EN;
        last = total + (gap ? T_RST : 0);

        @(negedge clk);
        bit_data  = tx_bits[0];
        bit_valid = 1'b1;
        frame_end = fe;
        nxt       = 1;
        for (int k = 1; k <= last + 1; k++) begin
            @(negedge clk);
            is_end = 1'b0;
            foreach (ends[j]) if (ends[j] == k) is_end = 1'b1;
            e_wave = (k <= total) ? exp_wave[k-1] : 1'b0;
            tag = $sformatf("%s c%0d", name, k);
            checkOutput({tag, " wave"},    wave,      e_wave);
            checkOutput({tag, " busy"},    busy,      k <= last);
            checkOutput({tag, " ready"},   bit_ready, is_end || (k == last + 1));
            checkOutput({tag, " bitdone"}, bit_done,  is_end);
            checkOutput({tag, " rstdone"}, rst_done,  gap && (k == last));
            // Data wiggles every cycle; only the value offered at a bit
            // boundary may matter.
            if (is_end && nxt < tx_bits.size()) begin
                bit_data  = tx_bits[nxt];
                bit_valid = 1'b1;
                nxt++;
            end else begin
                bit_data = 1'($urandom);
                if (is_end) bit_valid = 1'b0;
            end
            if (k == last + 1) frame_end = 1'b0;
        end
    endtask

    initial begin
        checks    = 0;
        fails     = 0;
        rst_n     = 1'b0;
        bit_data  = 1'b1;
        bit_valid = 1'b1;
        frame_end = 1'b0;

        // Reset values, with a bit offered while reset is held.
        #1;
        checkIdle("reset");
        repeat (3) @(negedge clk);
        checkIdle("reset held");
        rst_n     = 1'b1;
        bit_valid = 1'b0;
        @(negedge clk);
        checkIdle("after release");

        // Single bit 1, then bits 0,1,0 back to back.
        tx_bits = '{1'b1};
        applyStimulus("single1", 1'b0);
        tx_bits = '{1'b0, 1'b1, 1'b0};
        applyStimulus("seq010", 1'b0);

        // Bit 1 with frame_end high from the start: bit first, then gap.
        tx_bits = '{1'b1};
        applyStimulus("frame1", 1'b1);

        // Reset on cycle 10 of a bit-1 high phase.
        @(negedge clk);
        bit_data  = 1'b1;
        bit_valid = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            bit_valid = 1'b0;
            bit_data  = 1'($urandom);
        end
        checkOutput("abort pre wave", wave, 1'b1);
        checkOutput("abort pre busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        checkIdle("abort");
        @(negedge clk);
        checkIdle("abort held");
        rst_n = 1'b1;
        tx_bits = '{1'b0};
        applyStimulus("post abort0", 1'b0);

        // Random streams with random frame_end.
        for (int r = 0; r < 4; r++) begin
            int n;
            bit fe;
            tx_bits.delete();
            n  = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) tx_bits.push_back(1'($urandom_range(0, 1)));
            fe = 1'($urandom_range(0, 1));
            applyStimulus($sformatf("rand%0d", r), fe);
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
